// File: rtl/mulres_unpacker.sv
// mulres_unpacker: buffers 256-bit multiplier results in a small FIFO and
// streams each one out as BEAT_W-bit beats, least-significant beat first.
// Also tracks multiplications still in flight, so the operand source can
// be throttled before the FIFO can overflow.
module mulres_unpacker #(
  parameter int DEPTH  = 4,
  parameter int BEAT_W = 64,
  parameter int CNT_W  = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      issue,
  output logic                      issue_allow,
  input  logic                      in_valid,
  input  logic [255:0]              Q,
  output logic [BEAT_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int BEATS  = 256 / BEAT_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SUM_W  = ((CNT_W > LVL_W) ? CNT_W : LVL_W) + 1;

  localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;

  // Result storage. The FIFO is only a handful of entries deep, so the head
  // is read combinationally; that lets the current beat be presented in the
  // same cycle the entry becomes the head, without a read-latency bubble.
  logic [255:0]       mem_q [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [LVL_W-1:0]   level_q,    level_d;
  logic [BIDX_W-1:0]  beat_q,     beat_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic               overflow_q, overflow_d;

  logic               beat_fire;
  logic               final_pop;
  logic               push_ok;
  logic [255:0]       head;
  logic [BEAT_W-1:0]  head_beats [BEATS];
  logic [SUM_W-1:0]   commit_sum;

  // Split the head result into its beats, beat 0 being the LS slice.
  assign head = mem_q[rd_ptr_q];

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat_slice
      assign head_beats[gi] = head[gi*BEAT_W +: BEAT_W];
    end
  endgenerate

  // Transfer handshake decode: a final-beat transfer retires the head, and
  // a full FIFO can still take a push in the cycle that frees its slot.
  always_comb begin
    beat_fire = out_valid && out_ready;
    final_pop = beat_fire && (beat_q == LAST_BEAT);
    push_ok   = in_valid && ((level_q != FULL_LVL) || final_pop);
  end

  // Next-state for pointers, occupancy and beat position.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    beat_d   = beat_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (final_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_ok, final_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (beat_fire) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BIDX_W'(1);
    end
  end

  // Next-state for the in-flight counter (saturating both ends) and the
  // sticky overflow flag, which latches any dropped result.
  always_comb begin
    inflight_d = inflight_q;
    case ({issue, in_valid})
      2'b10: begin
        if (inflight_q != CNT_MAX) begin
          inflight_d = inflight_q + CNT_W'(1);
        end
      end
      2'b01: begin
        if (inflight_q != CNT_ZERO) begin
          inflight_d = inflight_q - CNT_W'(1);
        end
      end
      default: inflight_d = inflight_q;
    endcase

    overflow_d = overflow_q || (in_valid && !push_ok);
  end

  // Control state register; reset wins over any concurrent issue/in_valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      beat_q     <= '0;
      inflight_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage write; contents need no reset because level gates visibility.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= Q;
    end
  end

  // Outputs are decoded from registered state only, so issue_allow has no
  // combinational path from issue, in_valid or out_ready.
  always_comb begin
    commit_sum  = SUM_W'(inflight_q) + SUM_W'(level_q);
    issue_allow = commit_sum < SUM_W'(DEPTH);
    out_valid   = (level_q != '0);
    out_last    = out_valid && (beat_q == LAST_BEAT);
    out_data    = out_valid ? head_beats[beat_q] : '0;
    overflow    = overflow_q;
    level       = level_q;
  end

endmodule

// File: tb/tb_mulres_unpacker.sv
// Testbench for mulres_unpacker: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_mulres_unpacker;

  localparam int DEPTH   = 4;
  localparam int BEAT_W  = 64;
  localparam int CNT_W   = 6;
  localparam int BEATS   = 256 / BEAT_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clock = 1'b0;
  logic               reset;
  logic               issue;
  logic               issue_allow;
  logic               in_valid;
  logic [255:0]       Q;
  logic [BEAT_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               overflow;
  logic [2:0]         level;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: queue of whole results, current beat index, counters.
  logic [255:0] mq [$];
  int           mbeat;
  int           minfl;
  bit           movf;

  mulres_unpacker #(.DEPTH(DEPTH), .BEAT_W(BEAT_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .issue(issue), .issue_allow(issue_allow),
    .in_valid(in_valid), .Q(Q), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .overflow(overflow), .level(level)
  );

  always #5 clock = ~clock;

  task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    mbeat = 0;
    minfl = 0;
    movf  = 1'b0;
  endtask

  task automatic check_outputs(string ctx);
    logic [255:0]      head;
    logic [BEAT_W-1:0] exp_data;
    bit                exp_valid;
    exp_valid = (mq.size() > 0);
    exp_data  = '0;
    if (exp_valid) begin
      head     = mq[0];
      exp_data = head[mbeat*BEAT_W +: BEAT_W];
    end
    check({ctx, ".out_valid"},   256'(out_valid),   256'(exp_valid));
    check({ctx, ".out_data"},    256'(out_data),    256'(exp_data));
    check({ctx, ".out_last"},    256'(out_last),    256'(exp_valid && mbeat == BEATS-1));
    check({ctx, ".level"},       256'(level),       256'(mq.size()));
    check({ctx, ".overflow"},    256'(overflow),    256'(movf));
    check({ctx, ".issue_allow"}, 256'(issue_allow), 256'((minfl + mq.size()) < DEPTH));
  endtask

  task automatic model_update(bit iss, bit inv, logic [255:0] qv, bit rdy, bit rst);
    bit fire, pop, acc;
    if (rst) begin
      model_reset();
      return;
    end
    fire = (mq.size() > 0) && rdy;
    pop  = fire && (mbeat == BEATS-1);
    acc  = inv && ((mq.size() < DEPTH) || pop);
    if (fire) mbeat = pop ? 0 : mbeat + 1;
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(qv);
    if (inv && !acc) movf = 1'b1;
    if (iss && !inv && minfl < CNT_MAX) minfl++;
    else if (inv && !iss && minfl > 0) minfl--;
  endtask

  // One clock cycle: check outputs, drive inputs, then advance the model.
  task automatic step(string ctx, bit iss, bit inv, logic [255:0] qv, bit rdy, bit rst);
    @(negedge clock);
    check_outputs(ctx);
    issue = iss; in_valid = inv; Q = qv; out_ready = rdy; reset = rst;
    @(posedge clock);
    model_update(iss, inv, qv, rdy, rst);
  endtask

  logic [255:0] q34;

  initial begin
    reset = 1'b1; issue = 1'b0; in_valid = 1'b0; Q = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);

    // Reset state held while reset=1, with issue/in_valid ignored.
    step("rst", 1, 1, rand256(), 1, 1);
    step("rst", 0, 0, '0, 0, 1);

    // Single result streamed out LS word first.
    q34 = {64'd4, 64'd3, 64'd2, 64'd1};
    step("single", 0, 1, q34, 1, 0);
    for (int i = 0; i < 5; i++) step("single", 0, 0, '0, 1, 0);

    // Issue accounting against FIFO space.
    step("issue", 0, 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) step("issue", 1, 0, '0, 0, 0);
    #1 check("issue.allow_after3", 256'(issue_allow), 256'(1));
    step("issue", 1, 0, '0, 0, 0);
    #1 check("issue.allow_after4", 256'(issue_allow), 256'(0));
    step("issue", 0, 1, rand256(), 0, 0);
    #1 check("issue.level_after_res", 256'(level), 256'(1));
    check("issue.allow_after_res", 256'(issue_allow), 256'(0));
    step("issue", 1, 0, '0, 0, 0);

    // Overflow on the fifth result into a full FIFO, then a clean drain.
    step("ovf", 0, 0, '0, 0, 1);
    for (int i = 0; i < 5; i++) step("ovf", 0, 1, rand256(), 0, 0);
    #1 check("ovf.level_full", 256'(level), 256'(4));
    check("ovf.flag_set", 256'(overflow), 256'(1));
    for (int i = 0; i < 18; i++) step("ovf_drain", 0, 0, '0, 1, 0);
    #1 check("ovf.flag_sticky", 256'(overflow), 256'(1));

    // Push accepted on a full FIFO when the final-beat pop coincides.
    step("full_pop", 0, 0, '0, 0, 1);
    for (int i = 0; i < 4; i++) step("full_pop", 0, 1, rand256(), 0, 0);
    for (int i = 0; i < 3; i++) step("full_pop", 0, 0, '0, 1, 0);
    step("full_pop", 0, 1, rand256(), 1, 0);
    #1 check("full_pop.level", 256'(level), 256'(4));
    check("full_pop.overflow", 256'(overflow), 256'(0));
    for (int i = 0; i < 17; i++) step("full_pop_drain", 0, 0, '0, 1, 0);

    // Stalled consumer: ready alternates, each beat must be held.
    step("toggle", 0, 0, '0, 0, 1);
    step("toggle", 0, 1, rand256(), 0, 0);
    for (int i = 0; i < 9; i++) step("toggle", 0, 0, '0, (i % 2) == 0, 0);

    // Reset mid-transfer discards everything.
    step("midrst", 0, 0, '0, 0, 1);
    step("midrst", 0, 1, rand256(), 0, 0);
    step("midrst", 1, 1, rand256(), 0, 0);
    step("midrst", 0, 0, '0, 1, 0);
    step("midrst", 1, 1, rand256(), 1, 1);
    #1 check("midrst.out_valid", 256'(out_valid), 256'(0));
    check("midrst.level", 256'(level), 256'(0));
    check("midrst.overflow", 256'(overflow), 256'(0));
    check("midrst.issue_allow", 256'(issue_allow), 256'(1));
    step("midrst", 0, 0, '0, 0, 0);

    // In-flight counter saturation at both ends.
    for (int i = 0; i < 70; i++) step("sat_hi", 1, 0, '0, 1, 0);
    for (int i = 0; i < 59; i++) begin
      step("sat_dn", 0, 1, rand256(), 1, 0);
      for (int j = 0; j < 3; j++) step("sat_dn", 0, 0, '0, 1, 0);
    end
    for (int i = 0; i < 6; i++) step("sat_dn", 0, 0, '0, 1, 0);
    #1 check("sat.allow_at_4", 256'(issue_allow), 256'(0));
    for (int i = 0; i < 8; i++) begin
      step("sat_lo", 0, 1, rand256(), 1, 0);
      for (int j = 0; j < 3; j++) step("sat_lo", 0, 0, '0, 1, 0);
    end
    for (int i = 0; i < 6; i++) step("sat_lo", 0, 0, '0, 1, 0);
    for (int i = 0; i < 4; i++) step("sat_lo", 1, 0, '0, 1, 0);
    step("sat_lo", 0, 0, '0, 1, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      step("rand", ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3), rand256(),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) == 0));
    end
    step("final", 0, 0, '0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mulres_unpacker.md
MULRES_UNPACKER -- requirements
Module: mulres_unpacker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning result FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter BEAT_W, default 64, meaning output beat width; 256/BEAT_W = BEATS (default 4).
REQ-003 SHALL have parameter CNT_W, default 6, meaning width of the in-flight counter (must cover multiplier latency + DEPTH).
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-005 SHALL have port clock  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port issue  input  1  pulses in the cycle an operand pair enters the multiplier (its in_valid).
REQ-008 SHALL have port issue_allow  output  1  source may issue a new operand pair this cycle.
REQ-009 SHALL have port in_valid  input  1  multiplier out_valid; no backpressure possible.
REQ-010 SHALL have port Q  input  256  multiplier result, sampled when in_valid=1.
REQ-011 SHALL have port out_data  output  BEAT_W  current beat of head result.
REQ-012 SHALL have port out_valid  output  1  out_data valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts beat.
REQ-014 SHALL have port out_last  output  1  current beat is final beat of a result.
REQ-015 SHALL have port overflow  output  1  sticky: a result was dropped.
REQ-016 SHALL have port level  output  clog2(DEPTH)+1  FIFO occupancy in results.

Function
REQ-017 SHALL push Q into the FIFO tail when in_valid=1 and the push is accepted (REQ-022).
REQ-018 SHALL drive out_valid=1 whenever level>0; out_data = head[BEAT_W*beat +: BEAT_W], beat 0 = Q[63:0] (LS first).
REQ-019 SHALL hold out_data/out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL advance beat counter on out_valid&&out_ready; wrap BEATS-1 -> 0 and pop head on that final-beat transfer.
REQ-021 SHALL drive out_last=1 iff out_valid=1 and beat=BEATS-1.
REQ-022 SHALL accept a push when level<DEPTH, or when level=DEPTH and a final-beat pop occurs in the same cycle.
REQ-023 SHALL, on in_valid=1 with push not accepted, discard Q, leave FIFO unchanged, and set overflow=1 next cycle.
REQ-024 SHALL keep overflow=1 until reset.
REQ-025 SHALL update level: +1 push only, -1 pop only, unchanged on push+pop or neither.
REQ-026 SHALL maintain in-flight counter: +1 on issue only, -1 on in_valid only, unchanged when both or neither.
REQ-027 SHALL saturate in-flight at 0 (in_valid with counter 0) and at 2^CNT_W-1 (issue at max).
REQ-028 SHALL drive issue_allow = (inflight + level) < DEPTH, computed from registered state only (no combinational path from issue, in_valid, out_ready).
REQ-029 SHALL count an issue made while issue_allow=0 normally (no blocking, no flag).
REQ-030 SHALL hold wrap-around FIFO pointers of clog2(DEPTH) bits; full/empty derived from level.

Reset
REQ-031 SHALL, while reset=1, clear level, pointers, beat, inflight and overflow; out_valid=0, out_last=0, out_data=0, level=0.
REQ-032 SHALL drive issue_allow=1 in the first cycle after reset deasserts.
REQ-033 SHALL ignore issue and in_valid in any cycle reset=1; reset mid-transfer discards all buffered results and partial beats.

Verification
REQ-034 SHALL pass: single result Q=0x0004..0003..0002..0001 (64-bit words 1,2,3,4), out_ready=1 -> beats 1,2,3,4 on consecutive cycles, out_last on 4th, level 1->0.
REQ-035 SHALL pass: 5 back-to-back in_valid, out_ready=0, DEPTH=4 -> level=4, 5th dropped, overflow=1 and stays 1; then drain yields first 4 results intact.
REQ-036 SHALL pass: level=4, final-beat transfer coincident with in_valid -> new result accepted, level stays 4, overflow=0.
REQ-037 SHALL pass: 3 issue pulses, no in_valid -> issue_allow=1; 4th issue -> issue_allow=0; one in_valid with out_ready=0 -> inflight 3, level 1, issue_allow still 0.
REQ-038 SHALL pass: out_ready toggled 1,0,1,0 per cycle -> each beat held while out_ready=0, 4 beats complete over 8 cycles, no beat repeated or skipped.
REQ-039 SHALL pass: reset asserted after beat 1 of a 2-result FIFO -> next cycle out_valid=0, level=0, inflight=0, overflow=0, issue_allow=1.
